// File: rtl/avalon_write_master.sv
// Avalon-MM single-word write master fed by a show-ahead write-data FIFO.
// Optional stall cycle counter enabled with `define AVALON_WM_STALL_COUNT_EN.
module avalon_write_master #(
  parameter int DATAWIDTH       = 32,
  parameter int BYTEENABLEWIDTH = 4,
  parameter int ADDRESSWIDTH    = 26,
  parameter int FIFODEPTH       = 16,
  parameter int FIFODEPTH_LOG2  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       control_fixed_location,
  input  logic [ADDRESSWIDTH-1:0]    control_write_base,
  input  logic [ADDRESSWIDTH-1:0]    control_write_length,
  input  logic                       control_go,
  output logic                       control_done,
  input  logic                       user_write_buffer,
  input  logic [DATAWIDTH-1:0]       user_buffer_data,
  output logic                       user_buffer_full,
  output logic [ADDRESSWIDTH-1:0]    master_address,
  output logic                       master_write,
  output logic [BYTEENABLEWIDTH-1:0] master_byteenable,
  output logic [DATAWIDTH-1:0]       master_writedata,
  input  logic                       master_waitrequest,
`ifdef AVALON_WM_STALL_COUNT_EN
  output logic [31:0]                stall_count,
`endif
  output logic                       state_dbg
);

  localparam logic [ADDRESSWIDTH-1:0] STEP       = ADDRESSWIDTH'(BYTEENABLEWIDTH);
  localparam logic [ADDRESSWIDTH-1:0] ALIGN_MASK = ~ADDRESSWIDTH'(BYTEENABLEWIDTH - 1);
  localparam logic [FIFODEPTH_LOG2:0] FULL_CNT   = (FIFODEPTH_LOG2 + 1)'(FIFODEPTH);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                    state;
  logic [ADDRESSWIDTH-1:0]   length_q;
  logic                      fixed_q;

  logic [DATAWIDTH-1:0]      mem [FIFODEPTH];
  logic [FIFODEPTH_LOG2-1:0] wr_ptr;
  logic [FIFODEPTH_LOG2-1:0] rd_ptr;
  logic [FIFODEPTH_LOG2:0]   count;
  logic [FIFODEPTH_LOG2:0]   count_next;

  logic                      push;
  logic                      pop;
  logic                      last;
  logic [ADDRESSWIDTH-1:0]   go_length;
  logic                      go_accept;

  // Handshake: a word transfers on any rising edge where master_write is high
  // and master_waitrequest is low; address and data are held otherwise.
  assign push      = user_write_buffer && !user_buffer_full;
  assign pop       = master_write && !master_waitrequest;
  assign last      = (length_q == STEP);
  assign go_length = control_write_length & ALIGN_MASK;
  assign go_accept = (state == IDLE) && control_go && (go_length != '0);

  assign master_byteenable = '1;
  assign master_writedata  = mem[rd_ptr];
  assign state_dbg         = (state == RUN);

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      user_buffer_full <= 1'b0;
      for (int i = 0; i < FIFODEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= user_buffer_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count            <= count_next;
      user_buffer_full <= (count_next == FULL_CNT);
    end
  end

  // master_write looks ahead at the post-edge FIFO occupancy so it stays a
  // pure register output with no path from master_waitrequest.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      control_done   <= 1'b1;
      master_write   <= 1'b0;
      master_address <= '0;
      length_q       <= '0;
      fixed_q        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          master_write <= 1'b0;
          control_done <= 1'b1;
          if (go_accept) begin
            master_address <= control_write_base & ALIGN_MASK;
            length_q       <= go_length;
            fixed_q        <= control_fixed_location;
            control_done   <= 1'b0;
            state          <= RUN;
          end
        end
        RUN: begin
          if (pop) begin
            length_q <= length_q - STEP;
            if (!fixed_q) master_address <= master_address + STEP;
            if (last) begin
              state        <= IDLE;
              control_done <= 1'b1;
              master_write <= 1'b0;
            end else begin
              master_write <= (count_next != '0);
            end
          end else begin
            master_write <= (count_next != '0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AVALON_WM_STALL_COUNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (go_accept) begin
      stall_count <= '0;
    end else if (master_write && master_waitrequest && (stall_count != 32'hFFFF_FFFF)) begin
      stall_count <= stall_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_avalon_write_master.sv
// Directed bench for avalon_write_master with an Avalon slave model and
// address/data scoreboards; checks stall_count when AVALON_WM_STALL_COUNT_EN is set.
module tb_avalon_write_master;
  localparam int DW = 32;
  localparam int BEW = 4;
  localparam int AW = 26;
  localparam int FD = 16;
  localparam int FDL = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          control_fixed_location = 1'b0;
  logic [AW-1:0] control_write_base = '0;
  logic [AW-1:0] control_write_length = '0;
  logic          control_go = 1'b0;
  logic          control_done;
  logic          user_write_buffer = 1'b0;
  logic [DW-1:0] user_buffer_data = '0;
  logic          user_buffer_full;
  logic [AW-1:0] master_address;
  logic          master_write;
  logic [BEW-1:0] master_byteenable;
  logic [DW-1:0] master_writedata;
  logic          master_waitrequest = 1'b0;
  logic          state_dbg;
`ifdef AVALON_WM_STALL_COUNT_EN
  logic [31:0]   stall_count;
`endif

  always #5 clk = ~clk;

  avalon_write_master #(
    .DATAWIDTH(DW), .BYTEENABLEWIDTH(BEW), .ADDRESSWIDTH(AW),
    .FIFODEPTH(FD), .FIFODEPTH_LOG2(FDL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .control_fixed_location(control_fixed_location),
    .control_write_base(control_write_base),
    .control_write_length(control_write_length),
    .control_go(control_go),
    .control_done(control_done),
    .user_write_buffer(user_write_buffer),
    .user_buffer_data(user_buffer_data),
    .user_buffer_full(user_buffer_full),
    .master_address(master_address),
    .master_write(master_write),
    .master_byteenable(master_byteenable),
    .master_writedata(master_writedata),
    .master_waitrequest(master_waitrequest),
`ifdef AVALON_WM_STALL_COUNT_EN
    .stall_count(stall_count),
`endif
    .state_dbg(state_dbg)
  );

  int checks = 0;
  int errors = 0;
  logic [AW-1:0] addr_q[$];
  logic [DW-1:0] exp_q[$];
  int wr_count = 0;
  int stall_idx = -1;
  int stall_left = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slave model: decides waitrequest for the coming edge and scores each transfer.
  always @(negedge clk) begin
    if (reset && master_write) begin
      if (wr_count == stall_idx && stall_left > 0) begin
        master_waitrequest = 1'b1;
        stall_left--;
        if (addr_q.size() > 0 && exp_q.size() > 0) begin
          check("stall_addr", 64'(master_address), 64'(addr_q[0]));
          check("stall_data", 64'(master_writedata), 64'(exp_q[0]));
        end
      end else begin
        master_waitrequest = 1'b0;
        checks++;
        assert (addr_q.size() > 0 && exp_q.size() > 0) else begin
          errors++;
          $error("FAIL unexpected_write observed addr=%0h expected no write", master_address);
        end
        if (addr_q.size() > 0 && exp_q.size() > 0) begin
          check("wr_addr", 64'(master_address), 64'(addr_q.pop_front()));
          check("wr_data", 64'(master_writedata), 64'(exp_q.pop_front()));
          check("wr_be", 64'(master_byteenable), 64'hF);
        end
        wr_count++;
      end
    end else begin
      master_waitrequest = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    user_write_buffer = 1'b1;
    user_buffer_data  = d;
    if (exp_q.size() < FD) exp_q.push_back(d);
    tick();
    user_write_buffer = 1'b0;
  endtask

  task automatic go(input logic [AW-1:0] base, input logic [AW-1:0] len, input logic fixed);
    logic [AW-1:0] aligned;
    int n;
    aligned = base & ~AW'(BEW - 1);
    n = int'(len) / BEW;
    for (int i = 0; i < n; i++)
      addr_q.push_back(fixed ? aligned : aligned + AW'(BEW * i));
    control_write_base     = base;
    control_write_length   = len;
    control_fixed_location = fixed;
    control_go             = 1'b1;
    tick();
    control_go = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (control_done) break;
      tick();
    end
    check(tag, 64'(control_done), 64'd1);
  endtask

  task automatic scenario_single(input string tag);
    push(32'h0000_1234);
    go(26'h100, 26'd4, 1'b0);
    check({tag, "_done_c1"}, 64'(control_done), 64'd0);
    tick();
    check({tag, "_done_c2"}, 64'(control_done), 64'd0);
    check({tag, "_write_c2"}, 64'(master_write), 64'd1);
    tick();
    check({tag, "_done_c3"}, 64'(control_done), 64'd1);
    check({tag, "_write_c3"}, 64'(master_write), 64'd0);
    check({tag, "_drained"}, 64'(addr_q.size()), 64'd0);
  endtask

  initial begin
    int found;
    // Reset state
    repeat (3) tick();
    check("rst_done", 64'(control_done), 64'd1);
    check("rst_write", 64'(master_write), 64'd0);
    check("rst_addr", 64'(master_address), 64'd0);
    check("rst_full", 64'(user_buffer_full), 64'd0);
    check("rst_wdata", 64'(master_writedata), 64'd0);
    reset = 1'b1;
    tick();

    // 1: single write, done timing
    scenario_single("t1");

    // 2: four incrementing writes with a two-cycle stall on the second
    push(32'hA); push(32'hB); push(32'hC); push(32'hD);
    stall_idx  = wr_count + 1;
    stall_left = 2;
    go(26'h200, 26'd16, 1'b0);
    wait_done("t2_done", 40);
    check("t2_drained", 64'(addr_q.size()), 64'd0);
    check("t2_stall_used", 64'(stall_left), 64'd0);
`ifdef AVALON_WM_STALL_COUNT_EN
    check("t2_stall_count", 64'(stall_count), 64'd2);
`endif

    // 3: fixed address, unaligned base and length, data arrives after go
    go(26'h43, 26'd14, 1'b1);
    tick();
    check("t3_no_write_empty", 64'(master_write), 64'd0);
    for (int i = 0; i < 3; i++) push($urandom);
    wait_done("t3_done", 20);
    check("t3_drained", 64'(addr_q.size()), 64'd0);

    // 4: fill FIFO past depth, then drain 16 words
    for (int i = 0; i < 17; i++) begin
      push($urandom);
      if (i == 14) check("t4_full_15", 64'(user_buffer_full), 64'd0);
      if (i == 15) check("t4_full_16", 64'(user_buffer_full), 64'd1);
      if (i == 16) check("t4_full_17", 64'(user_buffer_full), 64'd1);
    end
    go(26'h1000, 26'd64, 1'b0);
    check("t4_full_go", 64'(user_buffer_full), 64'd1);
    tick();
    check("t4_full_wr", 64'(user_buffer_full), 64'd1);
    tick();
    check("t4_full_pop", 64'(user_buffer_full), 64'd0);
    wait_done("t4_done", 60);
    check("t4_addr_drained", 64'(addr_q.size()), 64'd0);
    check("t4_data_drained", 64'(exp_q.size()), 64'd0);

    // 5: zero length go, then go ignored mid-run
    go(26'h0, 26'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("t5_len0_done", 64'(control_done), 64'd1);
      check("t5_len0_write", 64'(master_write), 64'd0);
      tick();
    end
    go(26'h300, 26'd8, 1'b0);
    tick();
    check("t5_run_empty_write", 64'(master_write), 64'd0);
    check("t5_run_done", 64'(control_done), 64'd0);
    push(32'h5555_0001);
    found = 0;
    for (int i = 0; i < 10; i++) begin
      if (addr_q.size() == 1) begin found = 1; break; end
      tick();
    end
    check("t5_first_write", 64'(found), 64'd1);
    control_write_base   = 26'h500;
    control_write_length = 26'd4;
    control_go           = 1'b1;
    tick();
    control_go = 1'b0;
    tick();
    check("t5_ignored_done", 64'(control_done), 64'd0);
    check("t5_ignored_write", 64'(master_write), 64'd0);
    push(32'h5555_0002);
    wait_done("t5_done", 10);
    check("t5_drained", 64'(addr_q.size()), 64'd0);

    // 6: reset while the second write is stalled
    for (int i = 0; i < 4; i++) push($urandom);
    stall_idx  = wr_count + 1;
    stall_left = 1000;
    go(26'h600, 26'd16, 1'b0);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (master_write && master_waitrequest) begin found = 1; break; end
      tick();
    end
    check("t6_stalled", 64'(found), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("t6_rst_write", 64'(master_write), 64'd0);
    check("t6_rst_done", 64'(control_done), 64'd1);
    check("t6_rst_full", 64'(user_buffer_full), 64'd0);
    check("t6_rst_addr", 64'(master_address), 64'd0);
    stall_left = 0;
    addr_q.delete();
    exp_q.delete();
    tick();
    tick();
    reset = 1'b1;
    tick();
    scenario_single("t6_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/avalon_write_master.md
Name: avalon_write_master

Overview:
- Avalon-MM write master: the responder end of the user-side write-control and write-buffer interface.
- Accepts a transfer request (base, length, fixed/incrementing address) plus a stream of data words pushed into an internal FIFO.
- Issues single-word Avalon-MM writes to SDRAM/on-chip memory and reports completion on control_done.
- Sits between user logic and the system interconnect.

Parameters:
- DATAWIDTH, 32, data word width in bits.
- BYTEENABLEWIDTH, 4, bytes per word (DATAWIDTH/8); also the address increment.
- ADDRESSWIDTH, 26, byte-address width.
- FIFODEPTH, 16, write-data FIFO depth in words (power of 2).
- FIFODEPTH_LOG2, 4, log2(FIFODEPTH).

Ports:
- clk  input  1  single clock.
- reset  input  1  asynchronous, active-low reset.
- control_fixed_location  input  1  1 = do not increment address.
- control_write_base  input  ADDRESSWIDTH  start byte address.
- control_write_length  input  ADDRESSWIDTH  bytes to transfer.
- control_go  input  1  start request.
- control_done  output  1  idle/complete; held high until next accepted go.
- user_write_buffer  input  1  push user_buffer_data into FIFO.
- user_buffer_data  input  DATAWIDTH  push data.
- user_buffer_full  output  1  FIFO full; pushes ignored while high.
- master_address  output  ADDRESSWIDTH  Avalon byte address.
- master_write  output  1  Avalon write request.
- master_byteenable  output  BYTEENABLEWIDTH  always all ones.
- master_writedata  output  DATAWIDTH  FIFO head word.
- master_waitrequest  input  1  slave stall.

Behaviour:
- Reset (async, reset==0):
  - State IDLE, control_done=1, master_write=0, master_address=0, remaining length=0.
  - FIFO empty, user_buffer_full=0, master_writedata=0.
  - Takes effect immediately, including mid-burst; the in-flight write is abandoned.
- States: IDLE, RUN.
- IDLE:
  - control_done=1.
  - control_go=1 with latched length != 0 loads address = base with low log2(BYTEENABLEWIDTH) bits zeroed, length = control_write_length rounded down to a multiple of BYTEENABLEWIDTH, and fixed flag, then moves to RUN.
  - control_done drops the next cycle.
  - go with rounded length 0: stay IDLE, done stays 1, no writes.
- RUN:
  - master_write = FIFO not empty; driven from registers only, with no combinational path from master_waitrequest.
  - Transfer occurs when master_write && !master_waitrequest: pop FIFO, length -= BYTEENABLEWIDTH, address += BYTEENABLEWIDTH unless fixed.
  - Address wraps modulo 2^ADDRESSWIDTH.
  - On the transfer that takes length to 0, go to IDLE; control_done=1 the following cycle and master_write=0.
- While master_waitrequest is high, master_address and master_writedata are held stable.
- control_go in RUN is ignored.
- FIFO:
  - Show-ahead; master_writedata = head word.
  - Pushes are accepted in any state, so prefill before go is allowed.
  - user_buffer_full = (count == FIFODEPTH), registered.
  - A push while full is dropped, with no count change.
  - Simultaneous push and pop when not full leaves count unchanged.
  - A pop from full clears full the next cycle.
  - FIFO is not flushed on go or completion; surplus words remain for the next request.
- Latency: go accepted at edge N gives master_write high at N+1 if FIFO is non-empty.
- One write is outstanding at a time; there is no burstcount.

Optional Feature:
- Macro: AVALON_WM_STALL_COUNT_EN.
- Defined:
  - Adds output stall_count [31:0], counting cycles with master_write && master_waitrequest.
  - Cleared to 0 on reset and on an accepted go; saturates at 0xFFFFFFFF.
- Undefined: the port and counter do not exist; behaviour is otherwise identical.

Test Plan:
1. Push 0x00001234; go base=0x100, len=4, fixed=0, no waitrequest -> one write at 0x100, data 0x00001234, be=0xF; control_done low for exactly 2 cycles, then high.
2. Push 0xA,0xB,0xC,0xD; go base=0x200, len=16; waitrequest held 2 cycles on 2nd write -> writes at 0x200/0x204/0x208/0x20C with data A..D; address/data stable during stall; stall_count=2 when enabled.
3. go base=0x43, len=14, fixed=1, push 3 words -> base aligned to 0x40, length 12, three writes all at 0x40.
4. Push 17 words while idle (depth 16) -> full high after the 16th push, 17th dropped; go len=64 -> exactly 16 writes; full low the cycle after the first pop.
5. go len=0 -> no writes, done stays 1. Start len=8 with empty FIFO, pulse go again mid-RUN -> ignored; writes occur only as words are pushed, and done follows the 2nd write.
6. Assert reset during 2nd of 4 writes with waitrequest high -> master_write=0, control_done=1, user_buffer_full=0 immediately; after release, a new len=4 go behaves as in scenario 1.
